// File: rtl/painel_chamadas_pkg.sv
// Shared definitions for the call panel: FSM encoding and default geometry.
package painel_chamadas_pkg;
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_CHEGADA = 2'd1,
    SERVE        = 2'd2
  } estado_t;

  localparam int N_ANDARES_DEF = 5;
  localparam int W_ANDAR_DEF   = 3;
  localparam int TIMEOUT_DEF   = 64;
endpackage

// File: rtl/seletor_alvo.sv
// SCAN target selector: picks the next floor to serve from the pending calls.
module seletor_alvo #(
  parameter int N_ANDARES = 5,
  parameter int W_ANDAR   = 3
) (
  input  logic [N_ANDARES-1:0] pendentes,
  input  logic [W_ANDAR-1:0]   andar_atual,
  input  logic                 dir_sobe,
  output logic [W_ANDAR-1:0]   alvo,
  output logic                 valido,
  output logic                 novo_dir
);
  logic                 aqui_ok, acima_ok, abaixo_ok;
  logic [W_ANDAR-1:0]   acima, abaixo;

  always_comb begin
    aqui_ok   = 1'b0;
    acima_ok  = 1'b0;
    abaixo_ok = 1'b0;
    acima     = '0;
    abaixo    = '0;
    // Descending scan leaves the lowest floor above; ascending leaves the highest below.
    for (int i = N_ANDARES - 1; i >= 0; i--) begin
      if (pendentes[i] && (W_ANDAR'(i) > andar_atual)) begin
        acima_ok = 1'b1;
        acima    = W_ANDAR'(i);
      end
    end
    for (int i = 0; i < N_ANDARES; i++) begin
      if (pendentes[i] && (W_ANDAR'(i) < andar_atual)) begin
        abaixo_ok = 1'b1;
        abaixo    = W_ANDAR'(i);
      end
      if (pendentes[i] && (W_ANDAR'(i) == andar_atual))
        aqui_ok = 1'b1;
    end
  end

  always_comb begin
    alvo     = '0;
    valido   = |pendentes;
    novo_dir = dir_sobe;
    if (aqui_ok) begin
      alvo = andar_atual;
    end else if (dir_sobe) begin
      if (acima_ok) begin
        alvo = acima;
      end else if (abaixo_ok) begin
        alvo     = abaixo;
        novo_dir = 1'b0;
      end
    end else begin
      if (abaixo_ok) begin
        alvo = abaixo;
      end else if (acima_ok) begin
        alvo     = acima;
        novo_dir = 1'b1;
      end
    end
  end
endmodule

// File: rtl/painel_chamadas.sv
// Hall/cabin call controller: latches button presses, dispatches one-hot
// requests to the elevator in SCAN order and clears calls on arrival.
module painel_chamadas
  import painel_chamadas_pkg::*;
#(
  parameter int N_ANDARES = N_ANDARES_DEF,
  parameter int W_ANDAR   = W_ANDAR_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_ANDARES-1:0] botao,
  input  logic [W_ANDAR-1:0]   andar_atual,
  input  logic                 door_open,
  input  logic                 busy,
  output logic [N_ANDARES-1:0] req,
  output logic [N_ANDARES-1:0] pendentes,
  output logic [W_ANDAR-1:0]   andar_alvo,
  output logic                 dir_sobe,
  output logic                 erro
);
  localparam int TW = $clog2(TIMEOUT);

  estado_t              estado;
  logic [TW-1:0]        timer;
  logic [N_ANDARES-1:0] botao_q, rise, absorve, limpa, pend_next;
  logic [W_ANDAR-1:0]   sel_alvo;
  logic                 sel_valido, sel_dir, chegou;

  // Out-of-range indices map to an all-zero mask, so they never match a floor.
  function automatic logic [N_ANDARES-1:0] onehot(input logic [W_ANDAR-1:0] idx);
    logic [N_ANDARES-1:0] m;
    m = '0;
    for (int i = 0; i < N_ANDARES; i++)
      if (W_ANDAR'(i) == idx) m[i] = 1'b1;
    return m;
  endfunction

  seletor_alvo #(
    .N_ANDARES (N_ANDARES),
    .W_ANDAR   (W_ANDAR)
  ) u_seletor (
    .pendentes   (pendentes),
    .andar_atual (andar_atual),
    .dir_sobe    (dir_sobe),
    .alvo        (sel_alvo),
    .valido      (sel_valido),
    .novo_dir    (sel_dir)
  );

  // Arrival clear is applied after the new-press OR, so it wins over a same-cycle re-press.
  always_comb begin
    chegou    = (andar_atual == andar_alvo) && door_open;
    rise      = botao & ~botao_q;
    absorve   = door_open ? onehot(andar_atual) : '0;
    limpa     = (estado == WAIT_CHEGADA && chegou) ? onehot(andar_alvo) : '0;
    pend_next = (pendentes | (rise & ~absorve)) & ~limpa;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado     <= IDLE;
      timer      <= '0;
      botao_q    <= '0;
      pendentes  <= '0;
      req        <= '0;
      andar_alvo <= '0;
      dir_sobe   <= 1'b1;
      erro       <= 1'b0;
    end else begin
      botao_q   <= botao;
      pendentes <= pend_next;
      case (estado)
        IDLE: begin
          req <= '0;
          if (sel_valido) begin
            andar_alvo <= sel_alvo;
            req        <= onehot(sel_alvo);
            dir_sobe   <= sel_dir;
            timer      <= '0;
            estado     <= WAIT_CHEGADA;
          end
        end
        WAIT_CHEGADA: begin
          if (chegou) begin
            req    <= '0;
            timer  <= '0;
            estado <= SERVE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            erro   <= 1'b1;
            req    <= '0;
            timer  <= '0;
            estado <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        SERVE: begin
          req <= '0;
          if (!door_open) estado <= IDLE;
        end
        default: begin
          req    <= '0;
          estado <= IDLE;
        end
      endcase
    end
  end

  // busy is informational only; the elevator queues req internally.
  logic unused_busy;
  assign unused_busy = busy;
endmodule
